// File: rtl/rs_alu_sched.sv
// ALU reservation-station scheduler: dual free-entry allocation, age-ordered
// issue selection, and speculative-tag tracking with mispredict kill.
module rs_alu_sched #(
    parameter int ENTRIES     = 8,
    parameter int ENT_SEL     = 3,
    parameter int SPECTAG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_req1_i,
    input  logic                   alloc_req2_i,
    input  logic [SPECTAG_LEN-1:0] alloc_spectag1_i,
    input  logic [SPECTAG_LEN-1:0] alloc_spectag2_i,
    output logic                   alloc_grant_o,
    output logic [ENT_SEL-1:0]     alloc_addr1_o,
    output logic [ENT_SEL-1:0]     alloc_addr2_o,
    output logic [ENTRIES-1:0]     entry_we_o,
    input  logic [ENTRIES-1:0]     ready_vec_i,
    input  logic                   exe_busy_i,
    output logic                   issue_valid_o,
    output logic [ENT_SEL-1:0]     issue_addr_o,
    input  logic                   prmiss_i,
    input  logic                   prsuccess_i,
    input  logic [SPECTAG_LEN-1:0] prtag_i,
    input  logic [SPECTAG_LEN-1:0] specfixtag_i,
    output logic [ENTRIES-1:0]     busy_vec_o,
    output logic [ENT_SEL:0]       free_cnt_o,
    output logic                   full_o
);

    localparam int CNT_W = ENT_SEL + 1;

    logic [ENTRIES-1:0]     busy_q, busy_d;
    logic [ENTRIES-1:0]     older_q [ENTRIES];
    logic [ENTRIES-1:0]     older_d [ENTRIES];
    logic [SPECTAG_LEN-1:0] tag_q [ENTRIES];
    logic [SPECTAG_LEN-1:0] tag_d [ENTRIES];
    logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;

    logic [ENT_SEL-1:0]     free1, free2;
    logic                   found1, found2;
    logic [CNT_W-1:0]       req_cnt;
    logic                   grant;
    logic [ENTRIES-1:0]     we;
    logic [ENTRIES-1:0]     kill;
    logic [ENTRIES-1:0]     cand;
    logic                   blocked;
    logic                   sel_found;
    logic [ENT_SEL-1:0]     sel_idx;
    logic                   issue_fire;
    logic [ENTRIES-1:0]     issue_oh;
    logic [CNT_W-1:0]       kill_cnt;
    logic                   succ_eff;

    // Lowest and next-lowest free entries, from registered occupancy only
    always_comb begin
        free1  = '0;
        free2  = '0;
        found1 = 1'b0;
        found2 = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!busy_q[i]) begin
                if (!found1) begin
                    free1  = ENT_SEL'(i);
                    found1 = 1'b1;
                end else if (!found2) begin
                    free2  = ENT_SEL'(i);
                    found2 = 1'b1;
                end
            end
        end
    end

    assign req_cnt = CNT_W'(alloc_req1_i) + CNT_W'(alloc_req1_i & alloc_req2_i);
    assign grant   = rst_n & alloc_req1_i & ~prmiss_i & (req_cnt <= free_cnt_q);

    always_comb begin
        we = '0;
        if (grant) begin
            we[free1] = 1'b1;
            if (alloc_req2_i) begin
                we[free2] = 1'b1;
            end
        end
    end

    always_comb begin
        kill = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            kill[i] = prmiss_i & busy_q[i] & (|(tag_q[i] & specfixtag_i));
        end
    end

    assign cand = busy_q & ready_vec_i & ~kill;

    // Pick the candidate that no other candidate is older than
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        blocked   = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
                if (cand[j] && older_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            if (cand[i] && !blocked && !sel_found) begin
                sel_idx   = ENT_SEL'(i);
                sel_found = 1'b1;
            end
        end
    end

    assign issue_fire = rst_n & sel_found & ~exe_busy_i;

    always_comb begin
        issue_oh = '0;
        if (issue_fire) begin
            issue_oh[sel_idx] = 1'b1;
        end
    end

    assign succ_eff = prsuccess_i & ~prmiss_i;

    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            kill_cnt = kill_cnt + CNT_W'(kill[i]);
        end
    end

    // Next-state: occupancy, age matrix, speculative tags, free count
    always_comb begin
        busy_d     = (busy_q & ~issue_oh & ~kill) | we;
        older_d    = older_q;
        tag_d      = tag_q;
        free_cnt_d = free_cnt_q - (grant ? req_cnt : CNT_W'(0))
                     + CNT_W'(issue_fire) + kill_cnt;

        for (int i = 0; i < ENTRIES; i++) begin
            if (succ_eff) begin
                tag_d[i] = tag_q[i] & ~prtag_i;
            end
            if (kill[i]) begin
                tag_d[i] = '0;
            end
        end

        if (grant) begin
            for (int j = 0; j < ENTRIES; j++) begin
                older_d[j][free1] = busy_q[j];
            end
            older_d[free1] = '0;
            tag_d[free1]   = alloc_spectag1_i & (succ_eff ? ~prtag_i : '1);
            if (alloc_req2_i) begin
                // Slot 1 is older than slot 2 within the same dispatch group
                for (int j = 0; j < ENTRIES; j++) begin
                    older_d[j][free2] = busy_q[j] | (ENT_SEL'(j) == free1);
                end
                older_d[free2] = '0;
                tag_d[free2]   = alloc_spectag2_i & (succ_eff ? ~prtag_i : '1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            free_cnt_q <= CNT_W'(ENTRIES);
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            free_cnt_q <= free_cnt_d;
            for (int i = 0; i < ENTRIES; i++) begin
                older_q[i] <= older_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    assign alloc_grant_o = grant;
    assign alloc_addr1_o = rst_n ? free1 : '0;
    assign alloc_addr2_o = rst_n ? free2 : '0;
    assign entry_we_o    = we;
    assign issue_valid_o = issue_fire;
    assign issue_addr_o  = rst_n ? sel_idx : '0;
    assign busy_vec_o    = busy_q;
    assign free_cnt_o    = free_cnt_q;
    assign full_o        = rst_n & (free_cnt_q == '0);

endmodule
